pc_fetch_unit: RTL and testbench

Instruction-fetch front end for the RV32 core. It holds the program counter and issues word requests to instruction memory over a req/ack handshake. Each returned instruction is presented to decode through a one-entry valid/ready buffer. Redirects arrive on redirect_pc, which is driven by the next-PC mux2to1 (branch target vs. jump target); redirects flush any in-flight or buffered instruction.

---
 rtl/rv_core_pkg.sv | 18 +
 rtl/pc_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_core_pkg.sv
// Shared RV32 core definitions: fetch FSM states, datapath widths and the
// canonical NOP that fetch and decode both use as the empty-slot filler.
package rv_core_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2,
        S_ERR   = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word requests over req/ack
// and presents each returned instruction to decode through a one-entry buffer.
module pc_fetch_unit #(
    parameter logic [rv_core_pkg::XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [rv_core_pkg::XLEN-1:0] NOP_INSTR = rv_core_pkg::NOP_INSTR
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             redirect_valid,
    input  logic [rv_core_pkg::XLEN-1:0]     redirect_pc,
    output logic                             imem_req,
    output logic [rv_core_pkg::XLEN-1:0]     imem_addr,
    input  logic                             imem_ack,
    input  logic [rv_core_pkg::XLEN-1:0]     imem_rdata,
    output logic                             if_valid,
    input  logic                             if_ready,
    output logic [rv_core_pkg::XLEN-1:0]     if_pc,
    output logic [rv_core_pkg::XLEN-1:0]     if_instr,
    output logic                             misalign_err,
    output rv_core_pkg::fetch_state_t        fetch_state
);

    import rv_core_pkg::*;

    // Handshakes: imem_req stays high with imem_addr stable until a cycle with
    // imem_ack=1; an ack while imem_req=0 is ignored. Decode takes the buffered
    // instruction in any cycle where if_valid && if_ready.

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] pend_pc, pend_pc_n;
    logic            pend_err, pend_err_n;
    logic            imem_req_n;
    logic [XLEN-1:0] imem_addr_n;
    logic            if_valid_n;
    logic [XLEN-1:0] if_pc_n;
    logic [XLEN-1:0] if_instr_n;
    logic            misalign_n;
    logic            ack_v;
    logic            redir_mis;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            pend_pc      <= RESET_PC;
            pend_err     <= 1'b0;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            if_valid     <= 1'b0;
            if_pc        <= '0;
            if_instr     <= NOP_INSTR;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            pend_pc      <= pend_pc_n;
            pend_err     <= pend_err_n;
            imem_req     <= imem_req_n;
            imem_addr    <= imem_addr_n;
            if_valid     <= if_valid_n;
            if_pc        <= if_pc_n;
            if_instr     <= if_instr_n;
            misalign_err <= misalign_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        pend_pc_n  = pend_pc;
        pend_err_n = pend_err;
        if_valid_n = if_valid;
        if_pc_n    = if_pc;
        if_instr_n = if_instr;
        misalign_n = misalign_err;
        ack_v      = imem_ack && imem_req;
        redir_mis  = (redirect_pc[1:0] != 2'b00);

        if (redirect_valid) begin
            if_valid_n = 1'b0;
            if_instr_n = NOP_INSTR;
            misalign_n = redir_mis;
            if (imem_req && !ack_v) begin
                // A live request cannot be withdrawn; park the target until it drains.
                state_n    = S_FLUSH;
                pend_pc_n  = redirect_pc;
                pend_err_n = redir_mis;
            end else if (redir_mis) begin
                state_n = S_ERR;
            end else begin
                pc_n    = redirect_pc;
                state_n = S_REQ;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (ack_v) begin
                        if_instr_n = imem_rdata;
                        if_pc_n    = pc;
                        if_valid_n = 1'b1;
                        pc_n       = pc + XLEN'(INSTR_BYTES);
                        state_n    = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (if_valid && if_ready) begin
                        if_valid_n = 1'b0;
                        if_instr_n = NOP_INSTR;
                        state_n    = S_REQ;
                    end
                end
                S_FLUSH: begin
                    if (ack_v) begin
                        if (pend_err) begin
                            state_n = S_ERR;
                        end else begin
                            pc_n    = pend_pc;
                            state_n = S_REQ;
                        end
                    end
                end
                S_ERR: begin
                    state_n = S_ERR;
                end
                default: begin
                    state_n = S_REQ;
                end
            endcase
        end

        // Outputs are registered from the next state so a fresh request to the
        // new PC appears the cycle after any transition into S_REQ.
        imem_req_n  = (state_n == S_REQ) || (state_n == S_FLUSH);
        imem_addr_n = (state_n == S_REQ) ? pc_n : imem_addr;
    end

    assign fetch_state = state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: vector table for the streaming case plus
// hand-written sequences for stalls, redirects, misalignment, wrap and reset.
module tb_pc_fetch_unit;

    import rv_core_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic         clk;
    logic         rst_n;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ack;
    logic [31:0]  imem_rdata;
    logic         if_valid;
    logic         if_ready;
    logic [31:0]  if_pc;
    logic [31:0]  if_instr;
    logic         misalign_err;
    fetch_state_t fetch_state;

    int n_checks;
    int n_pass;
    int mem_wait;
    int wcnt;

    typedef struct {
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs[8];

    pc_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .misalign_err   (misalign_err),
        .fetch_state    (fetch_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acks after mem_wait idle cycles, data = addr ^ KEY.
    always @(negedge clk) begin
        if (imem_req) begin
            if (wcnt >= mem_wait) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr ^ KEY;
                wcnt       = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
                wcnt       = wcnt + 1;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            wcnt       = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        int n;
        n = 0;
        while (!if_valid && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_vld"}, {31'b0, if_valid}, 32'd1);
        chk({name, "_pc"}, if_pc, exp_pc);
        chk({name, "_instr"}, if_instr, exp_pc ^ KEY);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_req"},   {31'b0, imem_req},     32'd0);
        chk({name, "_addr"},  imem_addr,             32'h0);
        chk({name, "_vld"},   {31'b0, if_valid},     32'd0);
        chk({name, "_pc"},    if_pc,                 32'h0);
        chk({name, "_instr"}, if_instr,              NOP);
        chk({name, "_mis"},   {31'b0, misalign_err}, 32'd0);
    endtask

    initial begin
        int seen_req;
        int seen_vld;
        int n;

        n_checks = 0;
        n_pass   = 0;
        mem_wait = 0;
        wcnt     = 0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        if_ready = 1'b1;

        vecs[0] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0, NOP};
        vecs[1] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'hA5A5_A5A5};
        vecs[2] = '{1'b1, 1'b1, 32'h4, 1'b0, 32'h0, NOP};
        vecs[3] = '{1'b1, 1'b0, 32'h4, 1'b1, 32'h4, 32'hA5A5_A5A1};
        vecs[4] = '{1'b1, 1'b1, 32'h8, 1'b0, 32'h4, NOP};
        vecs[5] = '{1'b1, 1'b0, 32'h8, 1'b1, 32'h8, 32'hA5A5_A5AD};
        vecs[6] = '{1'b1, 1'b1, 32'hC, 1'b0, 32'h8, NOP};
        vecs[7] = '{1'b1, 1'b0, 32'hC, 1'b1, 32'hC, 32'hA5A5_A5A9};

        // Reset values and zero-wait streaming.
        do_reset();
        chk_reset_vals("rst");
        for (int i = 0; i < 8; i++) begin
            if_ready = vecs[i].rdy;
            tick();
            chk($sformatf("v%0d_req", i),   {31'b0, imem_req}, {31'b0, vecs[i].req});
            chk($sformatf("v%0d_addr", i),  imem_addr,         vecs[i].addr);
            chk($sformatf("v%0d_vld", i),   {31'b0, if_valid}, {31'b0, vecs[i].vld});
            chk($sformatf("v%0d_pc", i),    if_pc,             vecs[i].pc);
            chk($sformatf("v%0d_instr", i), if_instr,          vecs[i].instr);
        end

        // Decode stall in S_HOLD.
        if_ready = 1'b0;
        do_reset();
        tick();
        tick();
        seen_req = 0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (imem_req) seen_req++;
            if (!if_valid || if_pc != 32'h0 || if_instr != KEY) n++;
        end
        chk("stall_req", seen_req, 0);
        chk("stall_hold", n, 0);
        if_ready = 1'b1;
        tick();
        chk("stall_rel_req",  {31'b0, imem_req}, 32'd1);
        chk("stall_rel_addr", imem_addr, 32'h4);
        chk("stall_rel_vld",  {31'b0, if_valid}, 32'd0);
        wait_valid("stall_next", 32'h4);

        // Redirect while a request to 8 waits three cycles.
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        mem_wait = 3;
        tick();
        chk("fl_pre_addr", imem_addr, 32'h8);
        pulse_redirect(32'h0000_0100);
        chk("fl_state", {30'b0, fetch_state}, {30'b0, S_FLUSH});
        seen_vld = 0;
        n = 0;
        while (imem_addr == 32'h8 && n < 20) begin
            if (!imem_req) seen_req++;
            if (if_valid) seen_vld++;
            tick();
            n++;
        end
        chk("fl_wait_cycles", n, 3);
        chk("fl_no_vld", seen_vld + {31'b0, if_valid}, 0);
        chk("fl_new_addr", imem_addr, 32'h100);
        chk("fl_new_req", {31'b0, imem_req}, 32'd1);
        mem_wait = 0;
        wait_valid("fl_next", 32'h100);

        // Redirect coinciding with an ack: data discarded, refetch at target.
        do_reset();
        tick();
        pulse_redirect(32'h0000_0300);
        chk("rack_addr", imem_addr, 32'h300);
        chk("rack_vld", {31'b0, if_valid}, 32'd0);
        wait_valid("rack_next", 32'h300);

        // Misaligned redirect from S_HOLD, then recovery.
        if_ready = 1'b0;
        do_reset();
        tick();
        tick();
        pulse_redirect(32'h0000_0202);
        chk("mis_err", {31'b0, misalign_err}, 32'd1);
        chk("mis_vld", {31'b0, if_valid}, 32'd0);
        chk("mis_state", {30'b0, fetch_state}, {30'b0, S_ERR});
        seen_req = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (imem_req) seen_req++;
        end
        chk("mis_no_req", seen_req, 0);
        chk("mis_sticky", {31'b0, misalign_err}, 32'd1);
        if_ready = 1'b1;
        pulse_redirect(32'h0000_0200);
        chk("mis_clr", {31'b0, misalign_err}, 32'd0);
        chk("mis_rec_addr", imem_addr, 32'h200);
        wait_valid("mis_rec", 32'h200);

        // Misaligned redirect with a request outstanding drains into S_ERR.
        do_reset();
        mem_wait = 2;
        tick();
        pulse_redirect(32'h0000_0006);
        chk("mfl_err", {31'b0, misalign_err}, 32'd1);
        chk("mfl_req_held", {31'b0, imem_req}, 32'd1);
        chk("mfl_addr_held", imem_addr, 32'h0);
        n = 0;
        while (imem_req && n < 10) begin
            tick();
            n++;
        end
        chk("mfl_state", {30'b0, fetch_state}, {30'b0, S_ERR});
        chk("mfl_vld", {31'b0, if_valid}, 32'd0);
        tick();
        chk("mfl_no_req", {31'b0, imem_req}, 32'd0);
        mem_wait = 0;

        // Address wrap at the top of the space.
        if_ready = 1'b0;
        do_reset();
        tick();
        tick();
        pulse_redirect(32'hFFFF_FFFC);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        if_ready = 1'b1;
        tick();
        chk("wrap_pc0", if_pc, 32'hFFFF_FFFC);
        chk("wrap_instr0", if_instr, 32'h5A5A_5A59);
        tick();
        chk("wrap_addr1", imem_addr, 32'h0000_0000);
        chk("wrap_req1", {31'b0, imem_req}, 32'd1);
        wait_valid("wrap_next", 32'h0);

        // Reset in the middle of a pending request.
        do_reset();
        tick();
        tick();
        mem_wait = 5;
        tick();
        chk("mrst_pre_addr", imem_addr, 32'h4);
        rst_n = 1'b0;
        tick();
        chk_reset_vals("mrst");
        rst_n = 1'b1;
        mem_wait = 0;
        tick();
        chk("mrst_req", {31'b0, imem_req}, 32'd1);
        chk("mrst_addr", imem_addr, 32'h0);
        wait_valid("mrst_next", 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
